// File: rtl/program_loader_pkg.sv
// Shared constants and state type for the byte-stream program loader.
// Frame: SYNC, LEN_LO, LEN_HI, 4*N little-endian data bytes, XOR checksum.
package program_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned LEN_W             = 16;
  localparam int unsigned BYTES_PER_WORD    = WORD_W / BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte receive handshake plus program-memory write port of the loader.
// slave = loader side, master = byte source / memory side.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  import program_loader_pkg::*;

  logic                  rx_valid;
  logic [BYTE_W-1:0]     rx_data;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_W-1:0]     mem_wdata;
  logic                  mem_ready;

  modport master (
    output rx_valid, rx_data, mem_ready,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data, mem_ready,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Shifts data bytes into a 32-bit little-endian word and keeps the running
// XOR checksum of every data byte since the last clear.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] csum,
  output logic              last
);

  logic [1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word  <= '0;
      csum  <= '0;
      count <= '0;
    end else if (shift) begin
      // First byte of a word ends up in bits 7:0 after four shifts.
      word  <= {data, word[WORD_W-1:BYTE_W]};
      csum  <= csum ^ data;
      count <= count + 2'd1;
    end
  end

  // High while the byte being shifted in completes the current word.
  assign last = (count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Program loader: parses framed byte stream, writes words to program memory
// and holds the CPU in reset until a checksum-verified frame has landed.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
)(
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus,
  output logic             cpu_reset,
  output logic             done,
  output logic             error
);

  localparam int unsigned IDX_W = ADDR_WIDTH + 1;
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   idx_q;
  logic               rx_ready_q;
  logic               mem_we_q;

  logic               accept;
  logic               is_sync;
  logic [LEN_W-1:0]   frame_len;
  logic               len_lo_load;
  logic               len_hi_load;
  logic               write_done;
  logic               last_word;
  logic               asm_clear;
  logic               asm_shift;
  logic [WORD_W-1:0]  asm_word;
  logic [BYTE_W-1:0]  asm_csum;
  logic               asm_last;

  word_assembler u_asm (
    .clk   (clk),
    .reset (reset),
    .clear (asm_clear),
    .shift (asm_shift),
    .data  (bus.rx_data),
    .word  (asm_word),
    .csum  (asm_csum),
    .last  (asm_last)
  );

  assign accept     = bus.rx_valid && rx_ready_q;
  assign is_sync    = accept && (bus.rx_data == SYNC_BYTE);
  assign frame_len  = {bus.rx_data, len_q[7:0]};
  assign write_done = mem_we_q && bus.mem_ready;
  assign last_word  = (32'(idx_q) + 32'd1) == 32'(len_q);

  always_comb begin
    state_d     = state_q;
    asm_clear   = 1'b0;
    asm_shift   = 1'b0;
    len_lo_load = 1'b0;
    len_hi_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (is_sync) begin
          state_d   = ST_LEN0;
          asm_clear = 1'b1;
        end
      end
      ST_LEN0: begin
        if (accept) begin
          state_d     = ST_LEN1;
          len_lo_load = 1'b1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          len_hi_load = 1'b1;
          if (frame_len == '0 || 32'(frame_len) > DEPTH) state_d = ST_ERROR;
          else                                           state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          asm_shift = 1'b1;
          if (asm_last) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (write_done) state_d = last_word ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (accept) state_d = (bus.rx_data == asm_csum) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      rx_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= (state_d != ST_WRITE);
      mem_we_q   <= (state_d == ST_WRITE);
      cpu_reset  <= (state_d != ST_DONE);
      done       <= (state_d == ST_DONE);
      error      <= (state_d == ST_ERROR);
      if (len_lo_load) len_q[7:0]  <= bus.rx_data;
      if (len_hi_load) len_q[15:8] <= bus.rx_data;
      if (asm_clear)       idx_q <= '0;
      else if (write_done) idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = idx_q[ADDR_WIDTH-1:0];
  assign bus.mem_wdata = asm_word;

endmodule
